// File: rtl/cozy_io_ports.sv
// Multi-channel I/O block for cozy_cpu: per-channel output latch + strobe, receive FIFO, status register.
// Optional loopback (mask register, self-push on data write) is enabled by defining COZY_IO_LOOPBACK_EN.
module cozy_io_ports #(
  parameter int unsigned NCHAN = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [3:0]             io_addr,
  input  logic [15:0]            io_wdata,
  input  logic                   io_we,
  input  logic                   io_re,
  output logic [15:0]            io_rdata,
  output logic [NCHAN*WIDTH-1:0] out_data,
  output logic [NCHAN-1:0]       out_stb,
  input  logic [NCHAN*WIDTH-1:0] in_data,
  input  logic [NCHAN-1:0]       in_valid,
  output logic [NCHAN-1:0]       in_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0]       mem_q    [NCHAN][DEPTH];
  logic [PW-1:0]          wr_ptr_q [NCHAN];
  logic [PW-1:0]          wr_ptr_d [NCHAN];
  logic [PW-1:0]          rd_ptr_q [NCHAN];
  logic [PW-1:0]          rd_ptr_d [NCHAN];
  logic [WIDTH-1:0]       push_val [NCHAN];
  logic [NCHAN-1:0]       empty, full, push, pop, loop_act, hi_mask;
  logic [15:0]            rdata_q, rdata_d;
  logic [NCHAN*WIDTH-1:0] out_data_q, out_data_d;
  logic [NCHAN-1:0]       out_stb_q, out_stb_d;
  logic                   data_acc;
  logic                   unused_wdata;

  assign data_acc     = !io_addr[3];
  assign unused_wdata = ^io_wdata;
  assign io_rdata     = rdata_q;
  assign out_data     = out_data_q;
  assign out_stb      = out_stb_q;

`ifdef COZY_IO_LOOPBACK_EN
  logic [NCHAN-1:0] loop_mask_q, loop_mask_d;

  always_comb begin
    loop_mask_d = loop_mask_q;
    if (io_we && io_addr[3]) loop_mask_d = io_wdata[NCHAN-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) loop_mask_q <= '0;
    else          loop_mask_q <= loop_mask_d;
  end

  assign loop_act = loop_mask_q;
  assign hi_mask  = loop_mask_q;
`else
  assign loop_act = '0;
  assign hi_mask  = full;
`endif

  always_comb begin
    for (int unsigned n = 0; n < NCHAN; n++) begin
      empty[n] = (wr_ptr_q[n] == rd_ptr_q[n]);
      full[n]  = ((wr_ptr_q[n] ^ rd_ptr_q[n]) == FULL_XOR);
    end
  end

  assign in_ready = reset_n ? (~full & ~loop_act) : '0;

  // Looped channels hold in_ready low, so the external and loopback pushes never collide.
  always_comb begin
    for (int unsigned n = 0; n < NCHAN; n++) begin
      logic sel, ext_push, lb_push;
      sel         = data_acc && (io_addr[2:0] == 3'(n));
      ext_push    = in_valid[n] && in_ready[n];
      lb_push     = loop_act[n] && io_we && sel && !full[n];
      push[n]     = ext_push || lb_push;
      push_val[n] = lb_push ? io_wdata[WIDTH-1:0] : in_data[n*WIDTH +: WIDTH];
      pop[n]      = io_re && sel && !empty[n];
      wr_ptr_d[n] = wr_ptr_q[n] + PW'(push[n]);
      rd_ptr_d[n] = rd_ptr_q[n] + PW'(pop[n]);
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (io_re) begin
      rdata_d = '0;
      for (int unsigned n = 0; n < NCHAN; n++) begin
        if (io_addr[3]) begin
          rdata_d[n]     = !empty[n];
          rdata_d[8 + n] = hi_mask[n];
        end else if (pop[n]) begin
          rdata_d[15]          = 1'b1;
          rdata_d[WIDTH-1:0]   = mem_q[n][rd_ptr_q[n][AW-1:0]];
        end
      end
    end
  end

  always_comb begin
    out_data_d = out_data_q;
    out_stb_d  = '0;
    for (int unsigned n = 0; n < NCHAN; n++) begin
      if (io_we && data_acc && (io_addr[2:0] == 3'(n))) begin
        out_data_d[n*WIDTH +: WIDTH] = io_wdata[WIDTH-1:0];
        out_stb_d[n]                 = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q    <= '0;
      out_data_q <= '0;
      out_stb_q  <= '0;
      for (int unsigned n = 0; n < NCHAN; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
      end
    end else begin
      rdata_q    <= rdata_d;
      out_data_q <= out_data_d;
      out_stb_q  <= out_stb_d;
      for (int unsigned n = 0; n < NCHAN; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < NCHAN; n++) begin
      if (push[n]) mem_q[n][wr_ptr_q[n][AW-1:0]] <= push_val[n];
    end
  end

endmodule

// File: tb/tb_cozy_io_ports.sv
// Directed bench for cozy_io_ports at default parameters (4 channels, 8 bits, depth 4).
module tb_cozy_io_ports;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  io_addr;
  logic [15:0] io_wdata;
  logic        io_we, io_re;
  logic [15:0] io_rdata;
  logic [31:0] out_data;
  logic [3:0]  out_stb;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;

  int n_cmp = 0;
  int n_err = 0;

  cozy_io_ports #(.NCHAN(4), .WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata), .out_data(out_data),
    .out_stb(out_stb), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a);
    io_addr = a; io_re = 1'b1;
    tick();
    io_re = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    io_addr = a; io_wdata = d; io_we = 1'b1;
    tick();
    io_we = 1'b0;
  endtask

  task automatic push(input int ch, input logic [7:0] d);
    in_data = '0;
    in_data[ch*8 +: 8] = d;
    in_valid = 4'b0001 << ch;
    tick();
    in_valid = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; io_addr = '0; io_wdata = '0; io_we = 1'b0; io_re = 1'b0;
    in_data = '0; in_valid = '0;
    tick(); tick();
    chk("ready_in_reset", 32'(in_ready), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_stb", 32'(out_stb), 32'h0);
    chk("rst_rdata", 32'(io_rdata), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'hF);
    rd(4'h8);
    chk("rst_status", 32'(io_rdata), 32'h0);

    wr(4'h2, 16'h00A5);
    chk("wr2_data", out_data, 32'h00A5_0000);
    chk("wr2_stb", 32'(out_stb), 32'h4);
    tick();
    chk("wr2_stb_clear", 32'(out_stb), 32'h0);
    wr(4'h5, 16'h00FF);
    chk("wr5_data", out_data, 32'h00A5_0000);
    chk("wr5_stb", 32'(out_stb), 32'h0);

    push(1, 8'h11); push(1, 8'h22); push(1, 8'h33); push(1, 8'h44);
    chk("ch1_full_ready", 32'(in_ready), 32'hD);
    in_data = 32'h0000_5500; in_valid = 4'b0010;
    tick();
    in_valid = '0;
    chk("ch1_fifth_ready", 32'(in_ready), 32'hD);
    rd(4'h8);
    chk("ch1_status", 32'(io_rdata), 32'h0202);
    rd(4'h1); chk("ch1_rd0", 32'(io_rdata), 32'h8011);
    rd(4'h1); chk("ch1_rd1", 32'(io_rdata), 32'h8022);
    rd(4'h1); chk("ch1_rd2", 32'(io_rdata), 32'h8033);
    rd(4'h1); chk("ch1_rd3", 32'(io_rdata), 32'h8044);
    tick();
    chk("rdata_hold", 32'(io_rdata), 32'h8044);
    rd(4'h1); chk("ch1_rd_empty", 32'(io_rdata), 32'h0);
    rd(4'h6); chk("rd_ch6", 32'(io_rdata), 32'h0);

    push(0, 8'hAA); push(0, 8'hBB);
    in_data = 32'h0000_00CC; in_valid = 4'b0001; io_addr = 4'h0; io_re = 1'b1;
    tick();
    in_valid = '0; io_re = 1'b0;
    chk("conc_rd", 32'(io_rdata), 32'h80AA);
    rd(4'h8);
    chk("conc_status2", 32'(io_rdata), 32'h0001);
    push(0, 8'hDD); push(0, 8'hEE);
    rd(4'h8);
    chk("conc_status_full", 32'(io_rdata), 32'h0101);
    in_data = 32'h0000_00FF; in_valid = 4'b0001; io_addr = 4'h0; io_re = 1'b1;
    tick();
    in_valid = '0; io_re = 1'b0;
    chk("full_pop_rd", 32'(io_rdata), 32'h80BB);
    chk("full_pop_ready", 32'(in_ready), 32'hF);
    rd(4'h0); chk("drain_cc", 32'(io_rdata), 32'h80CC);
    rd(4'h0); chk("drain_dd", 32'(io_rdata), 32'h80DD);
    rd(4'h0); chk("drain_ee", 32'(io_rdata), 32'h80EE);
    rd(4'h0); chk("drain_empty", 32'(io_rdata), 32'h0);

    push(3, 8'h01); push(3, 8'h02); push(3, 8'h03);
    rd(4'h8);
    chk("ch3_status", 32'(io_rdata), 32'h0008);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_data", out_data, 32'h0);
    chk("midrst_rdata", 32'(io_rdata), 32'h0);
    chk("midrst_ready", 32'(in_ready), 32'h0);
    #1;
    reset_n = 1'b1;
    tick();
    rd(4'h8);
    chk("midrst_status", 32'(io_rdata), 32'h0);

`ifdef COZY_IO_LOOPBACK_EN
    wr(4'h8, 16'h0001);
    chk("lb_ready", 32'(in_ready), 32'hE);
    wr(4'h0, 16'h0042);
    chk("lb_stb", 32'(out_stb), 32'h1);
    chk("lb_out", out_data, 32'h0000_0042);
    chk("lb_ready2", 32'(in_ready), 32'hE);
    rd(4'h0);
    chk("lb_rd", 32'(io_rdata), 32'h8042);
    rd(4'h8);
    chk("lb_status", 32'(io_rdata), 32'h0100);
`else
    wr(4'h8, 16'h000F);
    chk("stwr_ready", 32'(in_ready), 32'hF);
    rd(4'h8);
    chk("stwr_status", 32'(io_rdata), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cozy_io_ports.md
Name: cozy_io_ports

Overview:
- Parametrised multi-channel I/O block for cozy_cpu.
- Replaces the single fixed 8-bit inport/outport pair with NCHAN channels, each WIDTH bits wide.
- Each channel has a latched output register with a write strobe, and a DEPTH-entry receive FIFO with a valid/ready handshake.
- The CPU accesses data and status through a small I/O address space with one-cycle read latency.

Parameters:
- NCHAN, 4: number of channels; legal range 1..8.
- WIDTH, 8: data bits per channel; legal range 1..15.
- DEPTH, 4: receive FIFO entries per channel; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- io_addr  in  4  bit 3 = 0: data access to channel io_addr[2:0]; bit 3 = 1: status/control register.
- io_wdata  in  16  CPU write data.
- io_we  in  1  write strobe, one cycle per write.
- io_re  in  1  read strobe, one cycle per read.
- io_rdata  out  16  registered read data.
- out_data  out  NCHAN*WIDTH  packed output latches; channel n occupies [n*WIDTH +: WIDTH].
- out_stb  out  NCHAN  one-cycle pulse per channel when its latch is written.
- in_data  in  NCHAN*WIDTH  packed input data.
- in_valid  in  NCHAN  input valid, per channel.
- in_ready  out  NCHAN  input ready, per channel.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All FIFOs empty.
  - out_data = 0, out_stb = 0, io_rdata = 0.
  - in_ready = 0 while reset_n is low.
  - Loopback mask = 0.
- in_ready[n] = !full[n] once out of reset. A push occurs when in_valid[n] && in_ready[n]. There is no same-cycle bypass: a full FIFO does not accept a push even when a pop occurs in that cycle.
- Data write (io_we, addr bit 3 = 0, channel < NCHAN):
  - Latch io_wdata[WIDTH-1:0] into out_data for the channel on the next edge.
  - Pulse out_stb for that channel for exactly one cycle, coincident with the updated latch.
  - Writes to a channel >= NCHAN are ignored.
- Data read (io_re, addr bit 3 = 0):
  - io_rdata is updated on the next edge: bit 15 = !empty; bits [WIDTH-1:0] = FIFO head; all other bits 0.
  - If the FIFO is not empty, it pops in the same edge.
  - Reading an empty channel, or a channel >= NCHAN, returns 16'h0000 with no side effect.
- Status read (io_re, addr bit 3 = 1):
  - io_rdata[7:0] = non-empty mask; io_rdata[15:8] = full mask.
  - Bits for channels >= NCHAN read 0.
  - No side effects.
- io_rdata holds its value until the next io_re.
- io_we and io_re asserted together: both take effect; the read returns pre-write state.
- Simultaneous pop (CPU) and push (external) on a non-full, non-empty FIFO: both succeed; occupancy is unchanged.
- Pointer arithmetic: log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
  - empty: pointers equal.
  - full: pointers differ only in the MSB.
- Reset asserted mid-operation discards all FIFO contents and latches immediately.

Optional Feature:
- Macro: COZY_IO_LOOPBACK_EN.
- When defined:
  - A write to the status address sets loopback mask = io_wdata[NCHAN-1:0].
  - For a looped channel, a data write also pushes the written value into that channel's own FIFO, if not full; if full, the value is dropped.
  - The looped channel ignores in_valid and drives in_ready = 0.
  - Status read returns the loopback mask in io_rdata[15:8] in place of the full mask.
- When undefined:
  - Writes to the status address are ignored.
  - No mask register is built.
  - Status read returns the full mask in io_rdata[15:8].

Test Plan:
- Reset: after reset, out_data = 0, out_stb = 0, io_rdata = 0, in_ready = 4'b1111; a status read returns 16'h0000.
- Output: write 16'h00A5 to channel 2 → out_data[23:16] = 8'hA5, out_stb = 4'b0100 for one cycle, other channels unchanged; a write to channel 5 changes nothing.
- FIFO order and full:
  - Push 8'h11, 8'h22, 8'h33, 8'h44 on channel 1 → in_ready[1] = 0; status = 16'h0202.
  - A fifth push with in_valid held is not accepted.
  - Four reads return 16'h8011, 16'h8022, 16'h8033, 16'h8044.
  - A fifth read returns 16'h0000.
- Concurrency: with 2 entries in channel 0, push and read in the same cycle → read returns the oldest entry and occupancy stays 2; with channel 0 full, push and pop together → push not accepted, occupancy becomes 3.
- Reset mid-fill: 3 entries in channel 3, pulse reset_n low → status = 16'h0000 and out_data = 0 immediately.
- Loopback (COZY_IO_LOOPBACK_EN): write 16'h0001 to status, write 16'h0042 to channel 0 → out_stb[0] pulses, in_ready[0] = 0, a read of channel 0 returns 16'h8042, and a status read returns 16'h0100 after the pop.
